sha3_padder_ctrl: RTL and testbench

Sequencing controller for the SHA-3 absorb path. It accepts the message as a stream of 32-bit words and instantiates `padder1` to format the final partial word with the 0x06 domain byte. It zero-fills the remainder of the rate block, ORs 0x80 into the last byte of the block, and presents each full rate block to the permutation core with a valid/ack handshake. It sits between the UART word assembler and the Keccak-f round engine.

---
 rtl/sha3_pkg.sv | 12 +
 rtl/sha3_padder_ctrl_padder1.sv | 16 +
 rtl/sha3_padder_ctrl.sv | 106 ++++++++++
 tb/tb_sha3_padder_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/sha3_pkg.sv
// Shared types and constants for the SHA-3 absorb-path padder controller.
package sha3_pkg;
  localparam int          RATE_WORDS_DEFAULT = 34;
  localparam logic [7:0]  PAD_FINAL          = 8'h80;
  localparam logic [7:0]  PAD_DOMAIN         = 8'h06;

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_PAD  = 2'd1,
    S_FULL = 2'd2
  } state_e;
endpackage

// File: rtl/sha3_padder_ctrl_padder1.sv
// Formats the final partial word: keeps the leading valid bytes and places the
// 0x06 domain byte right after them, zeroing everything below.
module padder1
  import sha3_pkg::*;
(
  input  logic [31:0] in_data,
  input  logic [1:0]  byte_num,
  output logic [31:0] out
);
  logic [31:0] keep_mask;
  logic [31:0] dom_word;

  assign keep_mask = ~(32'hFFFF_FFFF >> {byte_num, 3'b000});
  assign dom_word  = {PAD_DOMAIN, 24'h0} >> {byte_num, 3'b000};
  assign out       = (in_data & keep_mask) | dom_word;
endmodule

// File: rtl/sha3_padder_ctrl.sv
// Collects message words into a rate block, pads the tail with 0x06..0x80 and
// hands each complete block to the permutation core over a valid/ack handshake.
module sha3_padder_ctrl
  import sha3_pkg::*;
#(
  parameter int RATE_WORDS = RATE_WORDS_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [31:0]             in_data,
  input  logic                    in_valid,
  input  logic                    in_last,
  input  logic [1:0]              in_byte_num,
  output logic                    in_ready,
  output logic [RATE_WORDS*32-1:0] out_block,
  output logic                    out_valid,
  output logic                    out_last,
  input  logic                    out_ack
);
  localparam int CW = $clog2(RATE_WORDS + 1);

  state_e                  state_q;
  logic [CW-1:0]           cnt_q;
  logic [RATE_WORDS*32-1:0] block_q;
  logic                    valid_q, last_q;

  logic [31:0] pad_word;
  logic [31:0] wr_word;
  logic        wr_en;
  logic        idx_last;

  padder1 u_padder1 (
    .in_data  (in_data),
    .byte_num (in_byte_num),
    .out      (pad_word)
  );

  assign idx_last  = (cnt_q == CW'(RATE_WORDS - 1));
  assign in_ready  = (state_q == S_FILL);
  assign out_block = block_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;

  // Final-bit OR only touches padded words; a full data word at the last index is left alone.
  always_comb begin
    wr_en   = 1'b0;
    wr_word = '0;
    case (state_q)
      S_FILL: if (in_valid) begin
        wr_en   = 1'b1;
        wr_word = in_last ? pad_word : in_data;
        if (in_last && idx_last) wr_word = wr_word | {24'h0, PAD_FINAL};
      end
      S_PAD: begin
        wr_en   = 1'b1;
        if (idx_last) wr_word = {24'h0, PAD_FINAL};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FILL;
      cnt_q   <= '0;
      block_q <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      if (wr_en) block_q <= {block_q[RATE_WORDS*32-33:0], wr_word};
      case (state_q)
        S_FILL: if (in_valid) begin
          cnt_q <= cnt_q + 1'b1;
          if (in_last) begin
            if (idx_last) begin
              state_q <= S_FULL;
              valid_q <= 1'b1;
              last_q  <= 1'b1;
            end else begin
              state_q <= S_PAD;
            end
          end else if (idx_last) begin
            state_q <= S_FULL;
            valid_q <= 1'b1;
            last_q  <= 1'b0;
          end
        end
        S_PAD: begin
          cnt_q <= cnt_q + 1'b1;
          if (idx_last) begin
            state_q <= S_FULL;
            valid_q <= 1'b1;
            last_q  <= 1'b1;
          end
        end
        S_FULL: if (out_ack) begin
          state_q <= S_FILL;
          cnt_q   <= '0;
          valid_q <= 1'b0;
          last_q  <= 1'b0;
        end
        default: state_q <= S_FILL;
      endcase
    end
  end
endmodule

// File: tb/tb_sha3_padder_ctrl.sv
// Directed bench for sha3_padder_ctrl at RATE_WORDS=34.
module tb_sha3_padder_ctrl;
  localparam int RW = 34;

  logic              clk = 1'b0;
  logic              reset;
  logic [31:0]       in_data;
  logic              in_valid, in_last, in_ready;
  logic [1:0]        in_byte_num;
  logic [RW*32-1:0]  out_block;
  logic              out_valid, out_last, out_ack;

  int tests = 0;
  int fails = 0;
  logic [RW*32-1:0] eb;

  sha3_padder_ctrl #(.RATE_WORDS(RW)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_byte_num(in_byte_num), .in_ready(in_ready),
    .out_block(out_block), .out_valid(out_valid), .out_last(out_last),
    .out_ack(out_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] wordof(input int i);
    return out_block[(RW-1-i)*32 +: 32];
  endfunction

  task automatic set_word(input int i, input logic [31:0] w);
    eb[(RW-1-i)*32 +: 32] = w;
  endtask

  task automatic check_words(input string tag);
    for (int i = 0; i < RW; i++) chk($sformatf("%s_w%0d", tag, i), wordof(i), eb[(RW-1-i)*32 +: 32]);
  endtask

  task automatic beat(input logic [31:0] d, input logic last, input logic [1:0] bn);
    @(negedge clk);
    in_data = d; in_valid = 1'b1; in_last = last; in_byte_num = bn;
    @(posedge clk);
    #1 in_valid = 1'b0; in_last = 1'b0; in_data = 32'hDEAD_BEEF;
  endtask

  // Counts cycles after the last accepted beat until out_valid is seen.
  task automatic wait_valid(input string tag, input int exp_n);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 200);
    chk(tag, 32'(n), 32'(exp_n));
  endtask

  task automatic ack(input string tag);
    @(negedge clk);
    out_ack = 1'b1;
    @(posedge clk);
    #1 out_ack = 1'b0;
    @(negedge clk);
    chk({tag, "_vld_after_ack"}, 32'(out_valid), 32'd0);
    chk({tag, "_rdy_after_ack"}, 32'(in_ready), 32'd1);
    chk({tag, "_last_after_ack"}, 32'(out_last), 32'd0);
  endtask

  task automatic set_empty_block();
    eb = '0;
    set_word(0, 32'h0600_0000);
    set_word(RW-1, 32'h0000_0080);
  endtask

  initial begin
    reset = 1'b1; in_data = '0; in_valid = 1'b0; in_last = 1'b0;
    in_byte_num = '0; out_ack = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_last",  32'(out_last),  32'd0);
    chk("rst_ready", 32'(in_ready),  32'd1);
    chk("rst_block_lo", out_block[31:0], 32'd0);
    chk("rst_block_hi", out_block[RW*32-1 -: 32], 32'd0);
    reset = 1'b0;

    // Stray ack while idle must be ignored.
    out_ack = 1'b1;
    repeat (2) @(negedge clk);
    out_ack = 1'b0;
    chk("idle_ack_valid", 32'(out_valid), 32'd0);
    chk("idle_ack_ready", 32'(in_ready),  32'd1);

    // Empty message.
    beat(32'h1234_5678, 1'b1, 2'd0);
    wait_valid("empty_lat", RW);
    chk("empty_last", 32'(out_last), 32'd1);
    set_empty_block();
    check_words("empty");
    ack("empty");

    // One byte.
    beat(32'h61FF_FFFF, 1'b1, 2'd1);
    wait_valid("one_lat", RW);
    eb = '0; set_word(0, 32'h6106_0000); set_word(RW-1, 32'h0000_0080);
    check_words("one");
    ack("one");

    // 33 full words then a 3-byte tail: 0x06 and 0x80 merge into 0x86.
    eb = '0;
    for (int i = 0; i < RW-1; i++) begin
      beat(32'hA000_0000 | 32'(i), 1'b0, 2'd0);
      set_word(i, 32'hA000_0000 | 32'(i));
    end
    beat(32'hAABB_CCDD, 1'b1, 2'd3);
    set_word(RW-1, 32'hAABB_CC86);
    wait_valid("tail86_lat", 1);
    chk("tail86_last", 32'(out_last), 32'd1);
    check_words("tail86");
    ack("tail86");

    // 136-byte message: full block first, held without ack.
    eb = '0;
    for (int i = 0; i < RW; i++) begin
      beat(32'hC000_0000 | 32'(i), 1'b0, 2'd0);
      set_word(i, 32'hC000_0000 | 32'(i));
    end
    wait_valid("full_lat", 1);
    chk("full_last", 32'(out_last), 32'd0);
    check_words("full");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("hold%0d_valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("hold%0d_ready", k), 32'(in_ready), 32'd0);
      chk($sformatf("hold%0d_last",  k), 32'(out_last), 32'd0);
      tests++;
      assert (out_block === eb) else begin
        fails++;
        $error("FAIL hold%0d_block observed_lo=%h expected_lo=%h", k, out_block[63:0], eb[63:0]);
      end
    end
    ack("full");
    beat(32'h0, 1'b1, 2'd0);
    wait_valid("full2_lat", RW);
    chk("full2_last", 32'(out_last), 32'd1);
    set_empty_block();
    check_words("full2");
    ack("full2");

    // 5-byte message with random idle gaps.
    eb = '0; set_word(0, 32'h1122_3344); set_word(1, 32'h5506_0000); set_word(RW-1, 32'h0000_0080);
    for (int k = 0; k < int'($urandom_range(7, 1)); k++) begin
      @(negedge clk);
      in_data = $urandom;
    end
    beat(32'h1122_3344, 1'b0, 2'd0);
    begin
      int gap = int'($urandom_range(7, 1));
      for (int k = 0; k < gap; k++) begin
        @(negedge clk);
        in_data = $urandom; in_last = 1'b1;
        chk($sformatf("gap%0d_ready", k), 32'(in_ready), 32'd1);
        chk($sformatf("gap%0d_valid", k), 32'(out_valid), 32'd0);
      end
      in_last = 1'b0;
    end
    beat(32'h55AB_CDEF, 1'b1, 2'd1);
    wait_valid("gap_lat", RW-1);
    chk("gap_last", 32'(out_last), 32'd1);
    check_words("gap");
    ack("gap");

    // Reset mid-fill aborts the message.
    for (int i = 0; i < 10; i++) beat(32'hBEEF_0000 | 32'(i), 1'b0, 2'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_ready", 32'(in_ready),  32'd1);
    reset = 1'b0;
    beat(32'h0, 1'b1, 2'd0);
    wait_valid("postrst_lat", RW);
    chk("postrst_last", 32'(out_last), 32'd1);
    set_empty_block();
    check_words("postrst");
    ack("postrst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
